// File: rtl/puf_pkg.sv
// Shared definitions for the PUF key controller.
//   state_e  : sequencer states
//   TIMER_W  : width of the wait-state timeout counter
//   UCNT_W   : width of the saturating unstable-challenge counter
//   sat_inc  : saturating increment helper for the unstable counter
package puf_pkg;

   localparam int TIMER_W = 16;
   localparam int UCNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      WAIT_CH = 3'd2,
      EVAL    = 3'd3,
      WAIT_R  = 3'd4,
      ACC     = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
      if (v == {UCNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + UCNT_W'(1);
      end
   endfunction

endpackage

// File: rtl/puf_wait_timer.sv
// Timeout counter shared by the two wait states of the PUF key controller.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clr      : forces the count to zero (held while not waiting)
//   en       : counts one cycle per clock while waiting
//   expired  : high in the cycle whose increment brings the count to TIMEOUT,
//              i.e. during the TIMEOUT-th cycle spent waiting
module puf_wait_timer
   import puf_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // Next count: clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TIMER_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = en & (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/puf_key_ctrl.sv
// PUF key controller: requests challenges, launches one PUF evaluation per
// challenge and gathers one response bit per challenge into a NUM_BITS key.
// Each challenge is evaluated REPEAT times because the generator only
// advances its seed every REPEAT requests.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : pulse, begins a run (ignored unless idle)
//   busy, done          : run in progress / end-of-run pulse
//   key_valid, key      : collected key and its validity
//   err_timeout         : last run aborted waiting for generator or core
//   unstable_cnt        : challenges whose repeats disagreed (saturating)
//   gen_request/ready/challenge : challenge generator handshake
//   puf_start/challenge/done/resp : PUF evaluation core handshake
// Build option: define PUF_STABILITY_EN to enable repeat-mismatch tracking
// (key bit = first repeat, unstable_cnt active). Without it the key bit is
// the last repeat's response and unstable_cnt stays 0.
module puf_key_ctrl
   import puf_pkg::*;
#(
   parameter int NUM_BITS = 128,
   parameter int REPEAT   = 2,
   parameter int CHAL_W   = 128,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                key_valid,
   output logic [NUM_BITS-1:0] key,
   output logic                err_timeout,
   output logic [UCNT_W-1:0]   unstable_cnt,
   output logic                gen_request,
   input  logic                gen_ready,
   input  logic [CHAL_W-1:0]   gen_challenge,
   output logic                puf_start,
   output logic [CHAL_W-1:0]   puf_challenge,
   input  logic                puf_done,
   input  logic                puf_resp
);

   localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int REP_W = 6;

   state_e              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
   logic                resp_q, resp_d;
   logic [NUM_BITS-1:0] key_q, key_d;
   logic                key_valid_q, key_valid_d;
   logic                err_timeout_q, err_timeout_d;
   logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
   logic [CHAL_W-1:0]   chal_q, chal_d;
   logic                gen_request_q, gen_request_d;
   logic                puf_start_q, puf_start_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                bit_val_s;
   logic                tmr_wait_s;
   logic                tmr_expired_s;
`ifdef PUF_STABILITY_EN
   logic                ref_q, ref_d;
   logic                mismatch_q, mismatch_d;
   logic                unstable_now_s;
`endif

   assign tmr_wait_s = (state_q == WAIT_CH) || (state_q == WAIT_R);

   puf_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!tmr_wait_s),
      .en      (tmr_wait_s),
      .expired (tmr_expired_s)
   );

   // Sequencer next-state, datapath updates and next registered outputs.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rep_cnt_d     = rep_cnt_q;
      resp_d        = resp_q;
      key_d         = key_q;
      key_valid_d   = key_valid_q;
      err_timeout_d = err_timeout_q;
      ucnt_d        = ucnt_q;
      chal_d        = chal_q;
      bit_val_s     = resp_q;
`ifdef PUF_STABILITY_EN
      ref_d          = ref_q;
      mismatch_d     = mismatch_q;
      unstable_now_s = 1'b0;
      // First repeat defines the bit; later repeats are only compared with it.
      if (rep_cnt_q == REP_W'(0)) begin
         bit_val_s = resp_q;
      end else begin
         bit_val_s      = ref_q;
         unstable_now_s = mismatch_q | (resp_q != ref_q);
      end
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = REQ;
               key_valid_d   = 1'b0;
               err_timeout_d = 1'b0;
               ucnt_d        = '0;
               bit_cnt_d     = '0;
               rep_cnt_d     = '0;
`ifdef PUF_STABILITY_EN
               mismatch_d    = 1'b0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            state_d = WAIT_CH;
         end
         WAIT_CH: begin
            // A ready pulse in the expiry cycle still wins.
            if (gen_ready) begin
               chal_d  = gen_challenge;
               state_d = EVAL;
            end else if (tmr_expired_s) begin
               state_d       = ERR;
               err_timeout_d = 1'b1;
               key_valid_d   = 1'b0;
            end else begin
               state_d = WAIT_CH;
            end
         end
         EVAL: begin
            state_d = WAIT_R;
         end
         WAIT_R: begin
            if (puf_done) begin
               resp_d  = puf_resp;
               state_d = ACC;
            end else if (tmr_expired_s) begin
               state_d       = ERR;
               err_timeout_d = 1'b1;
               key_valid_d   = 1'b0;
            end else begin
               state_d = WAIT_R;
            end
         end
         ACC: begin
`ifdef PUF_STABILITY_EN
            if (rep_cnt_q == REP_W'(0)) begin
               ref_d = resp_q;
            end else begin
               ref_d = ref_q;
            end
            mismatch_d = unstable_now_s;
`endif
            if (rep_cnt_q < REP_W'(REPEAT - 1)) begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
               state_d   = REQ;
            end else begin
               key_d[bit_cnt_q] = bit_val_s;
               rep_cnt_d        = '0;
`ifdef PUF_STABILITY_EN
               if (unstable_now_s) begin
                  ucnt_d = sat_inc(ucnt_q);
               end else begin
                  ucnt_d = ucnt_q;
               end
               mismatch_d = 1'b0;
`endif
               if (bit_cnt_q == BIT_W'(NUM_BITS - 1)) begin
                  state_d     = DONE;
                  key_valid_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = REQ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      gen_request_d = (state_d == REQ);
      puf_start_d   = (state_d == EVAL);
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE) || (state_d == ERR);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         rep_cnt_q     <= '0;
         resp_q        <= 1'b0;
         key_q         <= '0;
         key_valid_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         ucnt_q        <= '0;
         chal_q        <= '0;
         gen_request_q <= 1'b0;
         puf_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rep_cnt_q     <= rep_cnt_d;
         resp_q        <= resp_d;
         key_q         <= key_d;
         key_valid_q   <= key_valid_d;
         err_timeout_q <= err_timeout_d;
         ucnt_q        <= ucnt_d;
         chal_q        <= chal_d;
         gen_request_q <= gen_request_d;
         puf_start_q   <= puf_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

`ifdef PUF_STABILITY_EN
   // Reference bit and mismatch flag for the challenge being repeated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_q      <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         ref_q      <= ref_d;
         mismatch_q <= mismatch_d;
      end
   end
`endif

   assign busy          = busy_q;
   assign done          = done_q;
   assign key_valid     = key_valid_q;
   assign key           = key_q;
   assign err_timeout   = err_timeout_q;
   assign unstable_cnt  = ucnt_q;
   assign gen_request   = gen_request_q;
   assign puf_start     = puf_start_q;
   assign puf_challenge = chal_q;

endmodule

// File: tb/tb_puf_key_ctrl.sv
// Self-checking bench for puf_key_ctrl: generator and PUF core models,
// table of run scenarios, plus hand-written reset sequences.
module tb_puf_key_ctrl;

   localparam int NB = 4;
   localparam int RP = 2;
   localparam int CW = 128;
   localparam int TO = 10;
   localparam logic [CW-1:0] SEED0 = 128'hC9F99D6C9F99D6C9F99D6C9F99D6C9F;

   typedef struct {
      int    dly;      // core delay in cycles, 0 = never answers
      int    mode;     // 0 resp=challenge lsb, 1 glitch on bit 2, 2 random
      bit    spam;     // hold start high during the run
      bit    exp_err;  // run expected to abort on timeout
      string name;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, key_valid, err_timeout;
   logic [NB-1:0] key;
   logic [15:0]   unstable_cnt;
   logic          gen_request;
   logic          gen_ready = 1'b0;
   logic [CW-1:0] gen_challenge = '0;
   logic          puf_start;
   logic [CW-1:0] puf_challenge;
   logic          puf_done = 1'b0;
   logic          puf_resp = 1'b0;

   int errors = 0;
   int checks = 0;

   // model state (written only by the model process)
   logic [CW-1:0] seed;
   logic [CW-1:0] chal_q[$];
   bit            resp_log[$];
   int            req_cnt = 0, gen_cnt = 0, core_cnt = 0, eval_idx = 0;
   bit            req_prev = 1'b0, cur_resp = 1'b0;
   int            req_edges = 0, puf_starts = 0, done_pulses = 0, chal_bad = 0;
   int            cyc = 0, start_cyc = 0, done_cyc = 0;
   // configuration (written only by the main process)
   int            mode = 0;
   int            core_dly_cfg = 3;

   vec_t tbl[9];

   puf_key_ctrl #(.NUM_BITS(NB), .REPEAT(RP), .CHAL_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .key_valid(key_valid), .key(key), .err_timeout(err_timeout),
      .unstable_cnt(unstable_cnt), .gen_request(gen_request),
      .gen_ready(gen_ready), .gen_challenge(gen_challenge),
      .puf_start(puf_start), .puf_challenge(puf_challenge),
      .puf_done(puf_done), .puf_resp(puf_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] next_seed(input logic [CW-1:0] s);
      return {s[CW-2:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
   endfunction

   // Generator and PUF core models, driven on the falling edge.
   always @(negedge clk) begin
      logic [CW-1:0] exp_ch;
      cyc = cyc + 1;
      if (!rst) begin
         seed = SEED0; req_cnt = 0; gen_cnt = 0; core_cnt = 0; eval_idx = 0;
         req_prev = 1'b0; gen_ready = 1'b0; puf_done = 1'b0;
         chal_q.delete();
      end else begin
         gen_ready = 1'b0;
         if (gen_cnt > 0) begin
            gen_cnt = gen_cnt - 1;
            if (gen_cnt == 0) begin
               gen_ready = 1'b1;
               gen_challenge = seed;
               chal_q.push_back(seed);
               req_cnt = req_cnt + 1;
               if (req_cnt % RP == 0) seed = next_seed(seed);
            end
         end
         if (gen_request && !req_prev) begin
            req_edges = req_edges + 1;
            gen_cnt = (mode == 2) ? int'($urandom_range(1, 4)) : 2;
         end
         req_prev = gen_request;

         puf_done = 1'b0;
         if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
               puf_done = 1'b1;
               puf_resp = cur_resp;
               resp_log.push_back(cur_resp);
            end
         end
         if (!busy) eval_idx = 0;
         if (puf_start) begin
            puf_starts = puf_starts + 1;
            start_cyc = cyc;
            if (chal_q.size() == 0) begin
               chal_bad = chal_bad + 1;
               exp_ch = '0;
            end else begin
               exp_ch = chal_q.pop_front();
               if (puf_challenge !== exp_ch) chal_bad = chal_bad + 1;
            end
            case (mode)
               1: cur_resp = (eval_idx == 4) ? 1'b1 : (eval_idx == 5) ? 1'b0 : exp_ch[0];
               2: cur_resp = 1'($urandom_range(0, 1));
               default: cur_resp = exp_ch[0];
            endcase
            eval_idx = eval_idx + 1;
            core_cnt = (mode == 2) ? int'($urandom_range(1, 9)) : core_dly_cfg;
         end
         if (done) begin
            done_pulses = done_pulses + 1;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string p);
      chk({p, ".busy"}, 128'(busy), 128'd0);
      chk({p, ".done"}, 128'(done), 128'd0);
      chk({p, ".key_valid"}, 128'(key_valid), 128'd0);
      chk({p, ".key"}, 128'(key), 128'd0);
      chk({p, ".err_timeout"}, 128'(err_timeout), 128'd0);
      chk({p, ".unstable_cnt"}, 128'(unstable_cnt), 128'd0);
      chk({p, ".gen_request"}, 128'(gen_request), 128'd0);
      chk({p, ".puf_start"}, 128'(puf_start), 128'd0);
      chk({p, ".puf_challenge"}, 128'(puf_challenge), 128'd0);
   endtask

   task automatic do_run(input vec_t v, input bit seed_key);
      int e0, s0, d0, l0, b0, runst;
      bit got, first, last, same;
      logic [NB-1:0] rkey;
      logic [CW-1:0] s;
      mode = v.mode;
      core_dly_cfg = v.dly;
      @(negedge clk); #1;
      e0 = req_edges; s0 = puf_starts; d0 = done_pulses; l0 = resp_log.size(); b0 = chal_bad;
      start = 1'b1;
      @(negedge clk); #1;
      start = v.spam;
      chk({v.name, ".busy_after_start"}, 128'(busy), 128'd1);
      chk({v.name, ".key_valid_cleared"}, 128'(key_valid), 128'd0);
      chk({v.name, ".err_cleared"}, 128'(err_timeout), 128'd0);
      got = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
         if (done) got = 1'b1;
         else begin
            @(negedge clk); #1;
            start = v.spam;
         end
      end
      start = 1'b0;
      chk({v.name, ".done_seen"}, 128'(got), 128'd1);
      chk({v.name, ".err_timeout"}, 128'(err_timeout), 128'(v.exp_err));
      chk({v.name, ".key_valid"}, 128'(key_valid), 128'(!v.exp_err));
      @(negedge clk); #1;
      chk({v.name, ".done_one_cycle"}, 128'(done), 128'd0);
      chk({v.name, ".idle_after"}, 128'(busy), 128'd0);
      chk({v.name, ".done_pulses"}, 128'(done_pulses - d0), 128'd1);
      chk({v.name, ".challenge_latch"}, 128'(chal_bad - b0), 128'd0);
      if (v.exp_err) begin
         chk({v.name, ".gen_edges"}, 128'(req_edges - e0), 128'd1);
         chk({v.name, ".puf_starts"}, 128'(puf_starts - s0), 128'd1);
         chk({v.name, ".timeout_latency"}, 128'(done_cyc - start_cyc), 128'(TO + 1));
      end else begin
         chk({v.name, ".gen_edges"}, 128'(req_edges - e0), 128'(NB * RP));
         chk({v.name, ".puf_starts"}, 128'(puf_starts - s0), 128'(NB * RP));
         if (resp_log.size() < l0 + NB * RP) begin
            chk({v.name, ".resp_count"}, 128'(resp_log.size() - l0), 128'(NB * RP));
         end else begin
            rkey = '0;
            runst = 0;
            for (int b = 0; b < NB; b++) begin
               first = resp_log[l0 + b * RP];
               last  = resp_log[l0 + b * RP + RP - 1];
               same  = 1'b1;
               for (int r = 0; r < RP; r++)
                  if (resp_log[l0 + b * RP + r] != first) same = 1'b0;
`ifdef PUF_STABILITY_EN
               rkey[b] = first;
               if (!same) runst++;
`else
               rkey[b] = last;
`endif
            end
            chk({v.name, ".key"}, 128'(key), 128'(rkey));
            chk({v.name, ".unstable_cnt"}, 128'(unstable_cnt), 128'(runst));
         end
         if (seed_key) begin
            s = SEED0;
            for (int b = 0; b < NB; b++) begin
               rkey[b] = s[0];
               s = next_seed(s);
            end
            chk({v.name, ".key_vs_seed"}, 128'(key), 128'(rkey));
         end
      end
   endtask

   initial begin
      vec_t pv;
      int   s0;
      bit   got;
      tbl[0] = '{3,  0, 1'b0, 1'b0, "basic"};
      tbl[1] = '{3,  1, 1'b0, 1'b0, "glitch"};
      tbl[2] = '{10, 0, 1'b0, 1'b0, "done_at_expiry"};
      tbl[3] = '{0,  0, 1'b0, 1'b1, "no_done"};
      tbl[4] = '{3,  0, 1'b1, 1'b0, "start_spam"};
      tbl[5] = '{1,  2, 1'b0, 1'b0, "rand_a"};
      tbl[6] = '{1,  2, 1'b0, 1'b0, "rand_b"};
      tbl[7] = '{11, 0, 1'b0, 1'b1, "done_late"};
      tbl[8] = '{1,  2, 1'b1, 1'b0, "rand_spam"};

      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_no_start", 128'(busy), 128'd0);

      for (int i = 0; i < 9; i++) begin
         do_run(tbl[i], i == 0);
         if (i == 1) begin
`ifdef PUF_STABILITY_EN
            chk("glitch.key2", 128'(key[2]), 128'd1);
            chk("glitch.unstable", 128'(unstable_cnt), 128'd1);
`else
            chk("glitch.key2", 128'(key[2]), 128'd0);
            chk("glitch.unstable", 128'(unstable_cnt), 128'd0);
`endif
         end
      end

      // asynchronous reset while waiting for the PUF core
      mode = 0;
      core_dly_cfg = 5;
      @(negedge clk); #1;
      s0 = puf_starts;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         if (puf_starts != s0) got = 1'b1;
         else begin
            @(negedge clk); #1;
         end
      end
      chk("midrst.reached_wait_r", 128'(got), 128'd1);
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      chk_zero("midrst");
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      pv = '{3, 0, 1'b0, 1'b0, "post_rst"};
      do_run(pv, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/puf_key_ctrl.md
Name: puf_key_ctrl

Overview:
Sequencer that drives the PUF challenge generator and the PUF evaluation core to produce a NUM_BITS-bit response key. On start it requests a challenge, launches one PUF evaluation per challenge, and collects one response bit per evaluation. The generator only advances its seed every REPEAT requests, so each challenge is evaluated REPEAT times. The block sits between the key-derivation/firmware interface and the challenge generator / PUF core pair.

Parameters:
NUM_BITS, 128, number of key bits collected (1..1024)
REPEAT, 2, evaluations per challenge; must equal the generator's challenge-repeat setting (1..63)
CHAL_W, 128, challenge width
TIMEOUT, 255, max cycles waiting for gen_ready or puf_done before abort (1..65535)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins key generation; ignored while busy
busy  out  1  high from the cycle after an accepted start until done
done  out  1  1-cycle pulse at the end of a run (success or timeout)
key_valid  out  1  level; key holds a complete result; cleared on accepted start
key  out  NUM_BITS  collected response bits, bit i = i-th challenge
err_timeout  out  1  level; last run aborted on timeout; cleared on accepted start
unstable_cnt  out  16  challenges whose REPEAT responses disagreed (saturating)
gen_request  out  1  request to challenge generator (generator detects the rising edge)
gen_ready  in  1  1-cycle pulse; gen_challenge is valid
gen_challenge  in  CHAL_W  challenge from generator
puf_start  out  1  1-cycle pulse launching a PUF evaluation
puf_challenge  out  CHAL_W  challenge latched for the PUF core; stable from puf_start until puf_done
puf_done  in  1  1-cycle pulse; puf_resp valid
puf_resp  in  1  response bit

Behaviour:
- Reset: all outputs 0, key 0, FSM in IDLE, all counters 0.
- States:
  - IDLE: start -> REQ; clears key_valid, err_timeout, unstable_cnt, bit_cnt, rep_cnt.
  - REQ: gen_request=1 for exactly one cycle -> WAIT_CH.
  - WAIT_CH: gen_request=0. gen_ready -> latch gen_challenge into puf_challenge, go to EVAL. Timer reaches TIMEOUT -> ERR.
  - EVAL: puf_start=1 for one cycle -> WAIT_R.
  - WAIT_R: puf_done -> ACC. Timer reaches TIMEOUT -> ERR.
  - ACC: rep_cnt==0 stores puf_resp as ref bit. Any later repeat differing from ref sets a mismatch flag.
    - rep_cnt<REPEAT-1: rep_cnt++ -> REQ.
    - Else: write ref bit to key[bit_cnt]; if flagged, unstable_cnt++ (saturates at 16'hFFFF); clear flag and rep_cnt.
    - Then bit_cnt==NUM_BITS-1 -> DONE; otherwise bit_cnt++ -> REQ.
  - DONE: done=1, key_valid=1 -> IDLE.
  - ERR: done=1, err_timeout=1, key_valid=0 -> IDLE. Partial key bits remain visible but are not valid.
- gen_request is low for at least 2 cycles between rising edges, as guaranteed by the WAIT_CH/EVAL/WAIT_R path.
- Timer: 16-bit, cleared on entry to WAIT_CH/WAIT_R, increments each cycle in those states. A ready/done pulse arriving in the same cycle the timer hits TIMEOUT wins; the run is not aborted.
- Stray gen_ready or puf_done outside the matching wait state is ignored.
- start asserted during busy is ignored. start in the DONE/ERR cycle is ignored.
- busy=1 in all states except IDLE.
- Latency, REPEAT=2, zero-delay core: (REQ+WAIT_CH(2)+EVAL+WAIT_R(k)+ACC) per evaluation.
- Async reset mid-run returns to IDLE immediately. The generator is reset with the same rst, so repeat phase stays aligned.

Optional Feature:
PUF_STABILITY_EN
- Defined: mismatch tracking and unstable_cnt are active as described.
- Not defined: no mismatch logic; key bit is the last repeat's response; unstable_cnt is tied to 0. All REPEAT evaluations are still issued to keep the generator phase aligned.

Decomposition:
- Package puf_pkg: state enum (IDLE, REQ, WAIT_CH, EVAL, WAIT_R, ACC, DONE, ERR); constants TIMER_W=16, UCNT_W=16.
- One sub-module, puf_wait_timer: 16-bit clear/enable counter with expiry compare against TIMEOUT, used by both wait states.

Test Plan:
- REPEAT=2, NUM_BITS=4; core model returns resp = challenge[0], 3-cycle delay, generator seed 128'hC9F99D6C9F99D6C9F99D6C9F99D6C9F -> 8 gen_request edges, 8 puf_start, key equals generator LSB sequence, key_valid=1, done pulse once, unstable_cnt=0.
- Same setup but core returns 1 then 0 on challenge #2 -> key[2]=1 (first repeat), unstable_cnt=1 (stability build); unstable_cnt=0 and key[2]=0 with PUF_STABILITY_EN undefined.
- Core never asserts puf_done, TIMEOUT=10 -> ERR after 10 cycles in WAIT_R, done pulse, err_timeout=1, key_valid=0; next start clears err_timeout.
- start pulsed every cycle during a run -> only one run; gen_request edges count = NUM_BITS*REPEAT exactly.
- rst deasserted->asserted mid-WAIT_R -> all outputs 0 next cycle, FSM IDLE; a fresh start yields a correct key.
- puf_done arriving on the same cycle the timer hits TIMEOUT -> bit accepted, no error.
